// File: rtl/stall_scheduler.sv
// rtl/stall_scheduler.sv - pipeline stall/flush scheduler with memory and mul/div wait FSM
module stall_scheduler #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_stall_ID,
  input  logic             Branch_ID,
  input  logic             mem_req_MEM,
  input  logic             mem_ack,
  input  logic             mdu_op_EXE,
  input  logic             mdu_done,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_DE_EN,
  output logic             reg_EM_EN,
  output logic             reg_MW_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic             reg_EM_flush,
  output logic             reg_MW_flush,
  output logic             mdu_go,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXE_WAIT = 2'd2,
    ABORT    = 2'd3
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic       mem_busy;
  logic       mdu_busy;

  assign state = cur_state;

  // A memory access still outstanding freezes the front of the pipe in every
  // state except the one-cycle abort, which itself drains everything.
  assign mem_busy = mem_req_MEM & ~mem_ack & (cur_state != ABORT);
  assign mdu_busy = ~mdu_done & ((cur_state == EXE_WAIT) |
                                 ((cur_state == RUN) & mdu_op_EXE));

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur_state <= RUN;
    else       cur_state <= nxt_state;
  end

  // Memory wait counter: held at zero outside MEM_WAIT, so every entry starts at 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      wait_cnt <= 8'd0;
    else if (cur_state != MEM_WAIT) wait_cnt <= 8'd0;
    else                            wait_cnt <= wait_cnt + 8'd1;
  end

  // Saturating count of cycles in which instruction fetch is held
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (!PC_EN_IF && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state, enables/flushes and pulses in priority order
  always_comb begin
    nxt_state    = cur_state;
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_DE_EN    = 1'b1;
    reg_EM_EN    = 1'b1;
    reg_MW_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_flush = 1'b0;
    reg_EM_flush = 1'b0;
    reg_MW_flush = 1'b0;
    mem_timeout  = 1'b0;
    mdu_go       = 1'b0;

    case (cur_state)
      RUN: begin
        if (mem_busy) begin
          nxt_state = MEM_WAIT;
        end else if (mdu_op_EXE && !mdu_done) begin
          nxt_state = EXE_WAIT;
          mdu_go    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack)                       nxt_state = RUN;
        else if (wait_cnt == MEM_TIMEOUT)  nxt_state = ABORT;
      end
      EXE_WAIT: begin
        if (mdu_done) nxt_state = RUN;
      end
      default: begin
        nxt_state = RUN;
      end
    endcase

    if (cur_state == ABORT) begin
      mem_timeout  = 1'b1;
      PC_EN_IF     = 1'b0;
      reg_FD_flush = 1'b1;
      reg_DE_flush = 1'b1;
      reg_EM_flush = 1'b1;
      reg_MW_flush = 1'b1;
    end else if (mem_busy) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_EM_EN    = 1'b0;
      reg_MW_flush = 1'b1;
    end else if (mdu_busy) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_EM_flush = 1'b1;
    end else if (load_stall_ID) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_DE_flush = 1'b1;
    end else if (Branch_ID) begin
      reg_FD_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_stall_scheduler.sv
// tb/tb_stall_scheduler.sv - randomized and directed checks of stall_scheduler against a reference model
module tb_stall_scheduler;

  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ld = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0, op = 1'b0, done = 1'b0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, em_fl, mw_fl, go, tmo;
  logic [CNT_W-1:0] scnt;
  logic [1:0]       st;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: state name, completed wait cycles, stall count
  int m_state  = 0;
  int m_waited = 0;
  int m_stall  = 0;
  logic [10:0] m_exp;

  always #5 clk = ~clk;

  stall_scheduler #(.MEM_TIMEOUT(8'(TO)), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .load_stall_ID(ld), .Branch_ID(br), .mem_req_MEM(req), .mem_ack(ack),
    .mdu_op_EXE(op), .mdu_done(done),
    .PC_EN_IF(pc_en), .reg_FD_EN(fd_en), .reg_DE_EN(de_en), .reg_EM_EN(em_en), .reg_MW_EN(mw_en),
    .reg_FD_flush(fd_fl), .reg_DE_flush(de_fl), .reg_EM_flush(em_fl), .reg_MW_flush(mw_fl),
    .mdu_go(go), .mem_timeout(tmo), .stall_cnt(scnt), .state(st)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] obs();
    return {pc_en, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, em_fl, mw_fl, go, tmo};
  endfunction

  // expected {PC,FD,DE,EM,MW enables, FD,DE,EM,MW flushes, go, timeout}
  function automatic logic [10:0] model_out();
    bit abort_c, mem_c, mdu_c;
    abort_c = (m_state == 3);
    mem_c   = !abort_c && req && !ack;
    mdu_c   = !done && (m_state == 2 || (m_state == 0 && op));
    if (abort_c)    return 11'b01111_1111_01;
    if (mem_c)      return 11'b00001_0001_00;
    if (mdu_c)      return {10'b00011_0010, (m_state == 0)} << 1;
    if (ld)         return 11'b00011_0100_00;
    if (br)         return 11'b11111_1000_00;
    return 11'b11111_0000_00;
  endfunction

  task automatic settle();
    @(negedge clk);
    m_exp = model_out();
    chk("outputs", 32'(obs()), 32'(m_exp));
    chk("state", 32'(st), 32'(m_state));
    chk("stall_cnt", 32'(scnt), 32'(m_stall));
  endtask

  task automatic advance();
    int ns;
    bit mem_c;
    mem_c = (m_state != 3) && req && !ack;
    ns = m_state;
    case (m_state)
      0: if (mem_c) begin ns = 1; m_waited = 0; end
         else if (op && !done) ns = 2;
      1: if (ack) ns = 0;
         else if (m_waited == TO) ns = 3;
         else m_waited++;
      2: if (done) ns = 0;
      default: ns = 0;
    endcase
    if (!m_exp[10] && m_stall < SMAX) m_stall++;
    m_state = ns;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic set_in(input logic l, b, r, a, o, d);
    ld = l; br = b; req = r; ack = a; op = o; done = d;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    m_state = 0; m_waited = 0; m_stall = 0;
    @(negedge clk);
    chk("reset_outputs", 32'(obs()), 32'(11'b11111_0000_00));
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_stall_cnt", 32'(scnt), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int ones, pulses, ab_seen;
    #1;
    do_reset();

    // memory wait acknowledged on the fourth cycle of the access
    set_in(0, 0, 1, 0, 0, 0);
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ack = 1'b1;
      settle();
      if (st == 2'd1) ones++;
      if (i == 0) chk("mem_stall_pc", 32'(pc_en), 32'd0);
      if (i == 1) chk("mem_mw_flush", 32'(mw_fl), 32'd1);
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0);
    settle();
    chk("mem_wait_cycles", 32'(ones), 32'd3);
    chk("mem_stall_total", 32'(scnt), 32'd3);
    chk("mem_back_run", 32'(st), 32'd0);
    advance();

    // mul/div op done on cycle 5
    do_reset();
    set_in(0, 0, 0, 0, 1, 0);
    pulses = 0; ones = 0;
    for (int i = 0; i < 6; i++) begin
      done = (i == 5);
      settle();
      pulses += int'(go);
      if (em_fl) ones++;
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0);
    settle();
    chk("mdu_go_pulses", 32'(pulses), 32'd1);
    chk("mdu_em_flush_cycles", 32'(ones), 32'd5);
    chk("mdu_back_run", 32'(st), 32'd0);
    advance();

    // memory busy inside EXE_WAIT
    do_reset();
    set_in(0, 0, 0, 0, 1, 0);
    tick();
    tick();
    req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      pulses += int'(go);
      chk("exe_mem_state", 32'(st), 32'd2);
      chk("exe_mem_em_en", 32'(em_en), 32'd0);
      advance();
    end
    chk("exe_mem_no_go", 32'(pulses), 32'd0);
    set_in(0, 0, 0, 0, 0, 1);
    tick();

    // memory timeout abort
    do_reset();
    set_in(0, 0, 1, 0, 0, 0);
    pulses = 0; ab_seen = -1;
    for (int i = 0; i < 10; i++) begin
      settle();
      pulses += int'(tmo);
      if (st == 2'd3) begin
        ab_seen = i;
        chk("abort_flushes", 32'({fd_fl, de_fl, em_fl, mw_fl}), 32'hF);
        req = 1'b0;
      end
      advance();
    end
    chk("abort_cycle", 32'(ab_seen), 32'(TO + 2));
    chk("abort_pulses", 32'(pulses), 32'd1);

    // load stall against branch
    do_reset();
    set_in(1, 1, 0, 0, 0, 0);
    settle();
    chk("ld_br_de_flush", 32'(de_fl), 32'd1);
    chk("ld_br_fd_flush", 32'(fd_fl), 32'd0);
    advance();
    set_in(0, 1, 0, 0, 0, 0);
    settle();
    chk("br_fd_flush", 32'(fd_fl), 32'd1);
    advance();

    // asynchronous reset in MEM_WAIT with wait_cnt == 2
    do_reset();
    set_in(0, 0, 1, 0, 0, 0);
    tick();
    tick();
    tick();
    settle();
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_state", 32'(st), 32'd0);
    chk("async_rst_stall", 32'(scnt), 32'd0);
    chk("async_rst_tmo", 32'(tmo), 32'd0);
    set_in(0, 0, 0, 0, 0, 0);
    m_state = 0; m_waited = 0; m_stall = 0;
    @(posedge clk);
    #1 rstn = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stall_scheduler.md
STALL_SCHEDULER -- requirements
Module: stall_scheduler

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8'd255: maximum MEM_WAIT cycles before abort.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 load_stall_ID  input  1  load-use stall request from the hazard detection unit.
REQ-006 Branch_ID  input  1  taken branch/jump resolved in ID, IF/ID must be flushed.
REQ-007 mem_req_MEM  input  1  load or store present in the MEM stage.
REQ-008 mem_ack  input  1  data memory completion, MEM-stage access done this cycle.
REQ-009 mdu_op_EXE  input  1  multi-cycle mul/div instruction present in EXE.
REQ-010 mdu_done  input  1  mul/div unit result valid this cycle.
REQ-011 PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN  output  1 each  pipeline register enables.
REQ-012 reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush  output  1 each  pipeline register flushes (insert bubble).
REQ-013 mdu_go  output  1  one-cycle start pulse to the mul/div unit.
REQ-014 mem_timeout  output  1  one-cycle error pulse on MEM_WAIT abort.
REQ-015 stall_cnt  output  CNT_W  saturating count of cycles with PC_EN_IF low.
REQ-016 state  output  2  current FSM state: RUN=0, MEM_WAIT=1, EXE_WAIT=2, ABORT=3.

Function
REQ-017 Stall/flush outputs SHALL be combinational from state and inputs; state, wait_cnt and stall_cnt SHALL be registered.
REQ-018 Priority SHALL be: ABORT > memory wait > mdu wait > load-use stall > branch flush.
REQ-019 mem_busy SHALL equal mem_req_MEM & ~mem_ack in RUN or MEM_WAIT.
REQ-020 mem_busy: all five enables low except reg_MW_EN high, reg_MW_flush high, all other flushes low.
REQ-021 mdu_busy (EXE_WAIT & ~mdu_done, or RUN & mdu_op_EXE & ~mdu_done) without mem_busy: PC_EN_IF, reg_FD_EN, reg_DE_EN low; reg_EM_EN high with reg_EM_flush high; reg_MW_EN high.
REQ-022 load_stall_ID with no higher-priority condition: PC_EN_IF, reg_FD_EN, reg_DE_EN low, reg_DE_flush high, EM/MW enabled.
REQ-023 Branch_ID SHALL assert reg_FD_flush only when no stall of any kind is active; suppressed otherwise.
REQ-024 No condition active: all enables high, all flushes low.
REQ-025 RUN -> MEM_WAIT when mem_busy; RUN -> EXE_WAIT when mdu_op_EXE & ~mdu_done & ~mem_busy; else stay RUN.
REQ-026 mdu_go SHALL pulse exactly on the RUN -> EXE_WAIT edge cycle (combinational on the transition condition), never in EXE_WAIT.
REQ-027 MEM_WAIT -> RUN on mem_ack; wait_cnt (8-bit) SHALL clear on entry and increment each MEM_WAIT cycle.
REQ-028 MEM_WAIT with wait_cnt == MEM_TIMEOUT and no mem_ack -> ABORT; mem_ack at that cycle wins (-> RUN).
REQ-029 ABORT lasts exactly one cycle: mem_timeout high, PC_EN_IF low, reg_FD/DE/EM/MW_flush all high, all enables high; then -> RUN.
REQ-030 EXE_WAIT -> RUN on mdu_done; mem_busy in EXE_WAIT SHALL take output priority while state stays EXE_WAIT.
REQ-031 stall_cnt SHALL increment each cycle PC_EN_IF is low and saturate at all-ones.
REQ-032 Branch_ID and load_stall_ID simultaneous: load stall wins, no FD flush.

Reset
REQ-033 rstn low SHALL asynchronously force state RUN, wait_cnt 0, stall_cnt 0.
REQ-034 During reset with inputs low: all enables 1, all flushes 0, mdu_go 0, mem_timeout 0.
REQ-035 Reset mid-MEM_WAIT or mid-EXE_WAIT SHALL abandon the wait with no mdu_go or mem_timeout pulse.

Verification
REQ-036 mem_req_MEM=1, mem_ack after 3 cycles -> state 1 for 3 cycles, reg_MW_flush=1, PC_EN_IF=0, stall_cnt=3, then RUN.
REQ-037 mdu_op_EXE=1, mdu_done on cycle 5 -> mdu_go single pulse at cycle 0, reg_EM_flush=1 cycles 0-4, state 2->0.
REQ-038 MEM_TIMEOUT=4, mem_ack never -> ABORT after 4 wait cycles, mem_timeout one pulse, all flushes 1, then RUN.
REQ-039 load_stall_ID=1 and Branch_ID=1 same cycle -> reg_DE_flush=1, reg_FD_flush=0; next cycle Branch_ID alone -> reg_FD_flush=1.
REQ-040 mem_busy during EXE_WAIT -> MEM outputs (reg_MW_flush=1, reg_EM_EN=0), state stays 2, no second mdu_go.
REQ-041 rstn low in MEM_WAIT with wait_cnt=2 -> immediate state 0, stall_cnt 0, no mem_timeout.
